synth_bus_responder: RTL
========================

# synth_bus_responder

Bus-side responder for the synth's parallel configuration bus. It samples the asynchronous BusClock strobe into the Clock domain, decodes BusAddress, and executes writes into the per-voice control registers: gate, phase increment, wave type, pulse width, sustain and linear mode. It returns register contents on BusData for reads, and produces per-voice gate edge pulses for the envelope logic. It sits between the external bus initiator and the voice/oscillator array inside TopLevel.

## Interface
- NUM_VOICES, 2, number of voices (1..15); voice v occupies addresses 0x00v0..0x00vF
- ID_VALUE, 8'hA5, constant returned at address 0x0000
- Clock  in  1  system clock; every register is on its rising edge
- Reset  in  1  synchronous, active-high reset
- BusAddress  in  16  register address; asynchronous to Clock
- BusData  inout  8  write data in; read data out; high-Z when not driving
- BusReadWrite  in  1  1 = write, 0 = read
- BusClock  in  1  transaction strobe; a transaction starts on its rising edge
- Gate  out  NUM_VOICES  gate bit per voice
- GateOn, GateOff  out  NUM_VOICES each  one-Clock pulse on a 0->1 or 1->0 gate transition
- Incr, WaveType, PulseWidth, Sustain  out  8*NUM_VOICES each  per-voice bytes; voice v at bits [8(v-1)+7 : 8(v-1)]
- Linear  out  NUM_VOICES  linear-envelope bit per voice

## Operation
- BusClock passes through a 2-flop synchronizer (s1, s2) and a delay flop s3. A strobe edge is s2 & !s3.
- On the strobe edge, BusAddress, BusData and BusReadWrite are sampled directly.
- Address decode:
  - The access is valid only if BusAddress[15:8] = 0.
  - v = BusAddress[7:4]; r = BusAddress[3:0].
  - v = 0 is the global page:
    - r = 0: ID_VALUE (read-only)
    - r = 1: NUM_VOICES (read-only)
    - r = 2: WriteCount, 8-bit
  - 1 <= v <= NUM_VOICES is the voice page:
    - r = 0: Gate (bit0)
    - r = 1: Incr
    - r = 2: WaveType
    - r = 3: PulseWidth
    - r = 4: Sustain
    - r = 5: Linear (bit0)
  - All other addresses are unmapped.
- Write:
  - A mapped writable register loads the sampled byte. Gate and Linear keep bit0 only.
  - Writes to read-only or unmapped addresses are ignored.
  - WriteCount increments by 1 for every accepted write to a voice register. It wraps 0xFF->0x00.
  - A write to 0x0002 clears WriteCount to 0x00 and is not itself counted.
- Gate edges: GateOn[v] pulses when Gate[v] changes 0->1, and GateOff[v] pulses when it changes 1->0. Writing the same gate value produces no pulse.
- Read:
  - ReadData is loaded on the strobe edge: the register value for mapped addresses, 0x00 for unmapped ones. Gate and Linear read back zero-extended.
  - BusData is driven with ReadData while a read is latched and s2 = 1. It returns to high-Z on the first cycle s2 = 0.
  - BusData is never driven during a write.
- Reset values:
  - Gate 0, Incr 0x00, WaveType 0x00, PulseWidth 0x80, Sustain 0xFF, Linear 0
  - WriteCount 0x00, GateOn/GateOff 0
  - BusData high-Z; s1, s2, s3 and the read latch cleared
- Reset mid-transaction: the transaction is lost.
- Post-reset arming: after reset deasserts, edge detection is armed only once s2 = 0 has been seen. A BusClock that is already high when Reset deasserts triggers nothing.

## Timing
- Call Clock edge k the first rising edge that samples BusClock = 1. Then:
  - s2 = 1 after edge k+1, so the strobe is detected during the cycle after k+1.
  - Write registers update on edge k+2 and the outputs are visible after edge k+2.
  - GateOn/GateOff are asserted for exactly the cycle after edge k+3.
- Initiator obligations:
  - Hold BusAddress, BusData and BusReadWrite stable from the BusClock rise through Clock edge k+2, i.e. at least 3 Clock periods.
  - Hold BusClock high for at least 1 Clock period and low for at least 2 Clock periods between strobes.
- Reads: BusData is valid from after edge k+2 until BusClock's fall has propagated through s2, which takes 2 cycles. The initiator samples read data on its falling BusClock edge, provided at least 3 Clock periods have passed since the rise.
- A back-to-back write and read to the same register returns the newly written value.
- Throughput: at most one transaction per 3 Clock periods.

## Test plan
- Reset released with BusClock low, no bus activity -> PulseWidth = 0x80, Sustain = 0xFF, Gate = 0, BusData = Z, and reading 0x0000 returns 0xA5.
- Write 0x0011 = 0x0F, then 0x0022 = 0x10 -> Incr[7:0] = 0x0F and WaveType[15:8] = 0x10, exactly 3 Clock edges after each strobe. Reading 0x0002 returns 0x02.
- Write 0x0010 = 0x01, then 0x0010 = 0x01 again, then 0x0010 = 0x00 -> one GateOn[0] pulse of 1 cycle, no second pulse, then one GateOff[0] pulse.
- Write 0x0103 = 0x55, 0x0036 = 0x55 and 0x0030 = 0x01 (NUM_VOICES = 2) -> no output changes and WriteCount unchanged. Reads of the same addresses return 0x00.
- Perform 257 voice writes, then read 0x0002 -> 0x01. Write 0x0002 = 0xXX, then read 0x0002 -> 0x00.
- Assert Reset for 1 cycle while BusClock is high mid-write to 0x0013 -> PulseWidth[7:0] stays 0x80, and no write occurs until BusClock goes low and then high again.

Source files
------------

// File: rtl/synth_bus_responder_if.sv
// rtl/synth_bus_responder_if.sv - configuration bus address/control/strobe bundle
interface synth_bus_responder_if;
   logic [15:0] BusAddress;
   logic        BusReadWrite;
   logic        BusClock;

   modport master (output BusAddress, output BusReadWrite, output BusClock);
   modport slave  (input  BusAddress, input  BusReadWrite, input  BusClock);
endinterface

// File: rtl/synth_bus_responder.sv
// rtl/synth_bus_responder.sv - synth config bus responder: strobe sync, decode, voice regs, gate edges
module synth_bus_responder #(
   parameter int         NUM_VOICES = 2,
   parameter logic [7:0] ID_VALUE   = 8'hA5
) (
   input  logic                      Clock,
   input  logic                      Reset,
   synth_bus_responder_if.slave      bus,
   inout  wire  [7:0]                BusData,
   output logic [NUM_VOICES-1:0]     Gate,
   output logic [NUM_VOICES-1:0]     GateOn,
   output logic [NUM_VOICES-1:0]     GateOff,
   output logic [8*NUM_VOICES-1:0]   Incr,
   output logic [8*NUM_VOICES-1:0]   WaveType,
   output logic [8*NUM_VOICES-1:0]   PulseWidth,
   output logic [8*NUM_VOICES-1:0]   Sustain,
   output logic [NUM_VOICES-1:0]     Linear
);

   logic                    s1_q, s2_q, s3_q;
   logic [1:0]              fill_q;
   logic                    armed_q, armed_d;
   logic                    rd_active_q, rd_active_d;
   logic [7:0]              rd_data_q, rd_data_d;
   logic [7:0]              wc_q, wc_d;
   logic [NUM_VOICES-1:0]   gate_q, gate_d, gate_prev_q, gate_on_q, gate_off_q;
   logic [NUM_VOICES-1:0]   lin_q, lin_d;
   logic [8*NUM_VOICES-1:0] incr_q, incr_d, wave_q, wave_d, pw_q, pw_d, sus_q, sus_d;

   logic       strobe;
   logic       page_ok;
   logic [3:0] v_sel, r_sel;
   logic [7:0] rd_mux;
   logic       voice_wr;

   assign strobe  = armed_q & s2_q & ~s3_q;
   assign page_ok = (bus.BusAddress[15:8] == 8'h00);
   assign v_sel   = bus.BusAddress[7:4];
   assign r_sel   = bus.BusAddress[3:0];

   always_comb begin
      incr_d      = incr_q;
      wave_d      = wave_q;
      pw_d        = pw_q;
      sus_d       = sus_q;
      gate_d      = gate_q;
      lin_d       = lin_q;
      wc_d        = wc_q;
      rd_data_d   = rd_data_q;
      rd_active_d = rd_active_q;
      rd_mux      = 8'h00;
      voice_wr    = 1'b0;
      // s2 is only trusted once the synchronizer has refilled after reset
      armed_d     = armed_q | (fill_q[1] & ~s2_q);

      if (page_ok && v_sel == 4'd0) begin
         case (r_sel)
            4'd0:    rd_mux = ID_VALUE;
            4'd1:    rd_mux = 8'(NUM_VOICES);
            4'd2:    rd_mux = wc_q;
            default: rd_mux = 8'h00;
         endcase
      end

      for (int i = 0; i < NUM_VOICES; i++) begin
         if (page_ok && v_sel == 4'(i + 1)) begin
            case (r_sel)
               4'd0:    rd_mux = {7'd0, gate_q[i]};
               4'd1:    rd_mux = incr_q[8*i +: 8];
               4'd2:    rd_mux = wave_q[8*i +: 8];
               4'd3:    rd_mux = pw_q[8*i +: 8];
               4'd4:    rd_mux = sus_q[8*i +: 8];
               4'd5:    rd_mux = {7'd0, lin_q[i]};
               default: rd_mux = 8'h00;
            endcase
            if (strobe && bus.BusReadWrite) begin
               voice_wr = (r_sel <= 4'd5);
               case (r_sel)
                  4'd0:    gate_d[i]          = BusData[0];
                  4'd1:    incr_d[8*i +: 8]   = BusData;
                  4'd2:    wave_d[8*i +: 8]   = BusData;
                  4'd3:    pw_d[8*i +: 8]     = BusData;
                  4'd4:    sus_d[8*i +: 8]    = BusData;
                  4'd5:    lin_d[i]           = BusData[0];
                  default: ;
               endcase
            end
         end
      end

      if (strobe && bus.BusReadWrite && page_ok && v_sel == 4'd0 && r_sel == 4'd2) begin
         wc_d = 8'h00;
      end else if (voice_wr) begin
         wc_d = wc_q + 8'd1;
      end

      if (strobe) begin
         rd_active_d = ~bus.BusReadWrite;
         if (!bus.BusReadWrite) begin
            rd_data_d = rd_mux;
         end
      end else if (!s2_q) begin
         rd_active_d = 1'b0;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         s1_q        <= 1'b0;
         s2_q        <= 1'b0;
         s3_q        <= 1'b0;
         fill_q      <= 2'b00;
         armed_q     <= 1'b0;
         rd_active_q <= 1'b0;
         rd_data_q   <= 8'h00;
         wc_q        <= 8'h00;
         gate_q      <= '0;
         gate_prev_q <= '0;
         gate_on_q   <= '0;
         gate_off_q  <= '0;
         lin_q       <= '0;
         incr_q      <= '0;
         wave_q      <= '0;
         pw_q        <= {NUM_VOICES{8'h80}};
         sus_q       <= {NUM_VOICES{8'hFF}};
      end else begin
         s1_q        <= bus.BusClock;
         s2_q        <= s1_q;
         s3_q        <= s2_q;
         fill_q      <= {fill_q[0], 1'b1};
         armed_q     <= armed_d;
         rd_active_q <= rd_active_d;
         rd_data_q   <= rd_data_d;
         wc_q        <= wc_d;
         gate_q      <= gate_d;
         gate_prev_q <= gate_q;
         gate_on_q   <= gate_q & ~gate_prev_q;
         gate_off_q  <= ~gate_q & gate_prev_q;
         lin_q       <= lin_d;
         incr_q      <= incr_d;
         wave_q      <= wave_d;
         pw_q        <= pw_d;
         sus_q       <= sus_d;
      end
   end

   assign BusData    = (rd_active_q && s2_q) ? rd_data_q : 8'hzz;
   assign Gate       = gate_q;
   assign GateOn     = gate_on_q;
   assign GateOff    = gate_off_q;
   assign Linear     = lin_q;
   assign Incr       = incr_q;
   assign WaveType   = wave_q;
   assign PulseWidth = pw_q;
   assign Sustain    = sus_q;

endmodule
